// File: rtl/otp_ctrl_edn_pack_arb.sv
// ---------------------------------------------------------------------------
// otp_ctrl_edn_pack_arb
//
// Arbitrates EDN entropy requests from NumClients internal consumers.
// Consumers are served round-robin. For the granted consumer the block
// collects NumWords = OutWidth/BusWidth EDN bus words and packs them into one
// wide word, first word in the LSBs. The packed word is then returned with a
// one-cycle ack.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   client_req_i    per-client request level        [NumClients]
//   client_ack_o    per-client one-cycle ack        [NumClients]
//   client_data_o   packed entropy, valid with ack  [OutWidth]
//   client_fips_o   AND of per-word FIPS flags, valid with ack
//   edn_req_o       request level towards EDN (high only while filling)
//   edn_ack_i       EDN word strobe
//   edn_bus_i       EDN word                        [BusWidth]
//   edn_fips_i      FIPS flag of the current EDN word
//   err_o           sticky: EDN strobe seen while not filling
// ---------------------------------------------------------------------------

// One packed word slot. Cleared after the packet has been delivered, so that
// entropy does not linger on the shared data bus.
module otp_ctrl_edn_pack_arb_slot #(
   parameter int BusWidth = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                we_i,
   input  logic                clr_i,
   input  logic [BusWidth-1:0] d_i,
   output logic [BusWidth-1:0] q_o
);
   logic [BusWidth-1:0] word_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_q <= '0;
      end else if (clr_i) begin
         word_q <= '0;
      end else if (we_i) begin
         word_q <= d_i;
      end
   end

   assign q_o = word_q;
endmodule

module otp_ctrl_edn_pack_arb #(
   parameter int NumClients = 2,
   parameter int BusWidth   = 32,
   parameter int OutWidth   = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NumClients-1:0] client_req_i,
   output logic [NumClients-1:0] client_ack_o,
   output logic [OutWidth-1:0]   client_data_o,
   output logic                  client_fips_o,
   output logic                  edn_req_o,
   input  logic                  edn_ack_i,
   input  logic [BusWidth-1:0]   edn_bus_i,
   input  logic                  edn_fips_i,
   output logic                  err_o
);
   localparam int NumWords = OutWidth / BusWidth;
   localparam int CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam int RrW      = (NumClients > 1) ? $clog2(NumClients) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StDeliver
   } state_e;

   state_e                  state_q;
   logic [RrW-1:0]          rr_q;
   logic [RrW-1:0]          grant_q;
   logic [CntW-1:0]         cnt_q;
   logic                    fips_q;
   logic                    fips_out_q;
   logic [NumClients-1:0]   ack_q;
   logic                    edn_req_q;
   logic                    err_q;

   logic                    gnt_vld_d;
   logic [RrW-1:0]          gnt_idx_d;
   logic                    fill_ack;
   logic                    last_word;
   logic                    clr_data;
   logic [NumWords-1:0][BusWidth-1:0] word_q;

   // Round-robin search: among requesters at or above rr_q the lowest index
   // wins; if there are none, the lowest requester overall wins (wrap).
   // Scanning downward lets the last hit be the lowest index.
   logic                    hi_any;
   logic [RrW-1:0]          hi_idx;
   logic [RrW-1:0]          lo_idx;

   always_comb begin
      gnt_vld_d = 1'b0;
      hi_any    = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      for (int j = NumClients - 1; j >= 0; j--) begin
         if (client_req_i[j]) begin
            gnt_vld_d = 1'b1;
            lo_idx    = RrW'(j);
            if (RrW'(j) >= rr_q) begin
               hi_any = 1'b1;
               hi_idx = RrW'(j);
            end
         end
      end
      gnt_idx_d = hi_any ? hi_idx : lo_idx;
   end

   assign fill_ack  = (state_q == StFill) && edn_ack_i;
   assign last_word = (cnt_q == CntW'(NumWords - 1));
   assign clr_data  = (state_q == StDeliver);

   // Word k is captured when the counter points at it.
   for (genvar k = 0; k < NumWords; k++) begin : g_word
      logic we;
      assign we = fill_ack && (cnt_q == CntW'(k));

      otp_ctrl_edn_pack_arb_slot #(
         .BusWidth (BusWidth)
      ) u_slot (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .we_i   (we),
         .clr_i  (clr_data),
         .d_i    (edn_bus_i),
         .q_o    (word_q[k])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         rr_q       <= '0;
         grant_q    <= '0;
         cnt_q      <= '0;
         fips_q     <= 1'b1;
         fips_out_q <= 1'b0;
         ack_q      <= '0;
         edn_req_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         // A strobe outside Fill is a protocol violation; the word itself is
         // dropped because the slots only load in Fill.
         if (edn_ack_i && (state_q != StFill)) begin
            err_q <= 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (gnt_vld_d) begin
                  grant_q   <= gnt_idx_d;
                  cnt_q     <= '0;
                  fips_q    <= 1'b1;
                  edn_req_q <= 1'b1;
                  state_q   <= StFill;
               end
            end

            StFill: begin
               if (edn_ack_i) begin
                  fips_q <= fips_q & edn_fips_i;
                  if (last_word) begin
                     // Counter is held on the last word so it never wraps.
                     edn_req_q  <= 1'b0;
                     ack_q      <= NumClients'(1) << grant_q;
                     fips_out_q <= fips_q & edn_fips_i;
                     state_q    <= StDeliver;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            StDeliver: begin
               ack_q      <= '0;
               fips_out_q <= 1'b0;
               rr_q       <= (grant_q == RrW'(NumClients - 1)) ? '0 : grant_q + 1'b1;
               state_q    <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign client_ack_o  = ack_q;
   assign client_data_o = word_q;
   assign client_fips_o = fips_out_q;
   assign edn_req_o     = edn_req_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_otp_ctrl_edn_pack_arb.sv
module tb_otp_ctrl_edn_pack_arb;
   localparam int NC = 2;
   localparam int BW = 32;
   localparam int OW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NC-1:0] client_req;
   logic [NC-1:0] client_ack;
   logic [OW-1:0] client_data;
   logic          client_fips;
   logic          edn_req;
   logic          edn_ack;
   logic [BW-1:0] edn_bus;
   logic          edn_fips;
   logic          err;

   otp_ctrl_edn_pack_arb #(
      .NumClients (NC),
      .BusWidth   (BW),
      .OutWidth   (OW)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .client_req_i  (client_req),
      .client_ack_o  (client_ack),
      .client_data_o (client_data),
      .client_fips_o (client_fips),
      .edn_req_o     (edn_req),
      .edn_ack_i     (edn_ack),
      .edn_bus_i     (edn_bus),
      .edn_fips_i    (edn_fips),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: round-robin pointer and sticky error.
   int rr_m  = 0;
   bit err_m = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // First requester at or after the pointer, with wrap.
   function automatic int model_grant(input logic [NC-1:0] req);
      for (int i = 0; i < NC; i++) begin
         int j;
         j = (rr_m + i) % NC;
         if (req[j]) return j;
      end
      return -1;
   endfunction

   // One full packet. Inputs change and outputs are checked on the falling
   // edge, so each loop step is exactly one clock.
   task automatic packet(input string nm, input logic [NC-1:0] req, input int gap,
                         input logic [BW-1:0] w0, input logic [BW-1:0] w1,
                         input bit f0, input bit f1, input bit drop);
      int            g;
      logic [BW-1:0] w[2];
      bit            f[2];
      logic [NC-1:0] exp_ack;
      w[0] = w0; w[1] = w1; f[0] = f0; f[1] = f1;
      g = model_grant(req);
      exp_ack = NC'(1) << g;
      client_req = req;
      @(negedge clk);
      chk({nm, ".edn_req_start"}, edn_req, 1);
      chk({nm, ".ack_early"}, client_ack, 0);
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < gap; s++) begin
            @(negedge clk);
            chk({nm, ".edn_req_stall"}, edn_req, 1);
         end
         edn_ack  = 1'b1;
         edn_bus  = w[k];
         edn_fips = f[k];
         @(negedge clk);
         edn_ack  = 1'b0;
         edn_bus  = $urandom;
         edn_fips = 1'($urandom);
         if (drop && k == 0) client_req = '0;
         if (k == 0) chk({nm, ".ack_mid"}, client_ack, 0);
      end
      chk({nm, ".ack"}, client_ack, exp_ack);
      chk({nm, ".data"}, client_data, {w[1], w[0]});
      chk({nm, ".fips"}, client_fips, 64'(f[0] & f[1]));
      chk({nm, ".err"}, err, 64'(err_m));
      chk({nm, ".edn_req_off"}, edn_req, 0);
      client_req = '0;
      @(negedge clk);
      chk({nm, ".ack_after"}, client_ack, 0);
      chk({nm, ".data_clr"}, client_data, 0);
      chk({nm, ".fips_after"}, client_fips, 0);
      rr_m = (g + 1) % NC;
   endtask

   initial begin
      rst_n      = 1'b0;
      client_req = '0;
      edn_ack    = 1'b0;
      edn_bus    = '0;
      edn_fips   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.ack", client_ack, 0);
      chk("rst.data", client_data, 0);
      chk("rst.fips", client_fips, 0);
      chk("rst.edn_req", edn_req, 0);
      chk("rst.err", err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single fill with fixed words.
      packet("single", 2'b01, 0, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0);

      // FIPS accumulation, then clean packet.
      packet("fips0", 2'b01, 0, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
      packet("fips1", 2'b10, 0, $urandom, $urandom, 1'b1, 1'b1, 1'b0);

      // Round robin, both requesting each packet.
      for (int p = 0; p < 4; p++)
         packet($sformatf("rr%0d", p), 2'b11, 0, $urandom, $urandom, 1'b1, 1'b1, 1'b0);

      // EDN stalls and request withdrawal.
      packet("stall", 2'b01, 5, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
      packet("drop", 2'b10, 1, $urandom, $urandom, 1'b1, 1'b1, 1'b1);

      // Protocol error: strobe while idle.
      edn_ack = 1'b1;
      edn_bus = $urandom;
      @(negedge clk);
      edn_ack = 1'b0;
      err_m   = 1'b1;
      chk("perr.err", err, 1);
      chk("perr.data", client_data, 0);
      packet("perr_pkt", 2'b11, 0, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk("perr.sticky", err, 1);

      // Reset mid-fill: rr_m is 1 here, so the interrupted grant is client 1.
      client_req = 2'b11;
      @(negedge clk);
      edn_ack = 1'b1;
      edn_bus = $urandom;
      @(negedge clk);
      edn_ack = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst.ack", client_ack, 0);
      chk("mrst.data", client_data, 0);
      chk("mrst.fips", client_fips, 0);
      chk("mrst.edn_req", edn_req, 0);
      chk("mrst.err", err, 0);
      client_req = '0;
      rr_m  = 0;
      err_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      packet("post_rst", 2'b11, 0, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
      packet("random", 2'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
             $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
